// File: rtl/pinball_game_fsm.sv
// rtl/pinball_game_fsm.sv - pinball game-flow controller (optional macro: PINBALL_BONUS_LIFE_EN)
module pinball_game_fsm #(
    parameter int SCORE_W        = 8,
    parameter int LEVEL_W        = 4,
    parameter int LIFE_W         = 3,
    parameter int INIT_LIVES     = 3,
    parameter int MAX_LIVES      = 5,
    parameter int HITS_PER_LEVEL = 2,
    parameter int MAX_LEVEL      = 3,
    parameter int POINTS_PER_HIT = 5,
    localparam int HITS_W        = $clog2(HITS_PER_LEVEL + 1)
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               key_start,
    input  logic               key_pause,
    input  logic               collision_bottom,
    input  logic               collision_obstacle,
    output logic               start,
    output logic               pause,
    output logic               reset_level,
    output logic               game_over,
    output logic               win,
    output logic [SCORE_W-1:0] score,
    output logic [LEVEL_W-1:0] level,
    output logic [LIFE_W-1:0]  life,
    output logic [HITS_W-1:0]  hits
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SERVE     = 3'd1;
    localparam logic [2:0] PLAY      = 3'd2;
    localparam logic [2:0] PAUSED    = 3'd3;
    localparam logic [2:0] GAME_OVER = 3'd4;
    localparam logic [2:0] WIN       = 3'd5;

    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(MAX_LEVEL - 1);
    localparam logic [LIFE_W-1:0]  LIFE_INIT  = LIFE_W'(INIT_LIVES);
    localparam logic [LIFE_W-1:0]  LIFE_CAP   = LIFE_W'(MAX_LIVES);
    localparam logic [HITS_W-1:0]  HITS_DONE  = HITS_W'(HITS_PER_LEVEL);
`ifdef PINBALL_BONUS_LIFE_EN
    localparam logic BONUS_EN = 1'b1;
`else
    localparam logic BONUS_EN = 1'b0;
`endif

    logic [2:0]         state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [LIFE_W-1:0]  life_q,  life_d;
    logic [HITS_W-1:0]  hits_q,  hits_d;
    // {start, pause, bottom, obstacle} as seen last cycle
    logic [3:0]         key_prev_q, key_prev_d;

    logic [3:0]         key_now;
    logic [3:0]         key_edge;
    logic               start_edge, pause_edge, bottom_edge, obstacle_edge;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_sat;
    logic [HITS_W-1:0]  hits_inc;

    assign key_now       = {key_start, key_pause, collision_bottom, collision_obstacle};
    assign key_edge      = key_now & ~key_prev_q;
    assign start_edge    = key_edge[3];
    assign pause_edge    = key_edge[2];
    assign bottom_edge   = key_edge[1];
    assign obstacle_edge = key_edge[0];

    // One extra bit catches the carry so the score clamps instead of wrapping
    assign score_sum = {1'b0, score_q} + (SCORE_W + 1)'(POINTS_PER_HIT);
    assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    assign hits_inc  = hits_q + HITS_W'(1);

    // Next-state and counter update; bottom beats obstacle beats pause in PLAY
    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        level_d    = level_q;
        life_d     = life_q;
        hits_d     = hits_q;
        key_prev_d = key_now;
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d = SERVE;
                    score_d = '0;
                    level_d = '0;
                    hits_d  = '0;
                    life_d  = LIFE_INIT;
                end
            end
            SERVE: begin
                if (start_edge) state_d = PLAY;
            end
            PLAY: begin
                if (bottom_edge) begin
                    if (life_q == LIFE_W'(1)) begin
                        life_d  = '0;
                        state_d = GAME_OVER;
                    end else begin
                        life_d  = life_q - LIFE_W'(1);
                        state_d = SERVE;
                    end
                end else if (obstacle_edge) begin
                    score_d = score_sat;
                    if (hits_inc == HITS_DONE) begin
                        hits_d = '0;
                        if (level_q == LAST_LEVEL) begin
                            state_d = WIN;
                        end else begin
                            level_d = level_q + LEVEL_W'(1);
                            state_d = SERVE;
                            if (BONUS_EN && (life_q < LIFE_CAP)) life_d = life_q + LIFE_W'(1);
                        end
                    end else begin
                        hits_d = hits_inc;
                    end
                end else if (pause_edge) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (pause_edge) state_d = PLAY;
            end
            GAME_OVER, WIN: begin
                if (start_edge) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and input history registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            score_q    <= '0;
            level_q    <= '0;
            life_q     <= LIFE_INIT;
            hits_q     <= '0;
            key_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            level_q    <= level_d;
            life_q     <= life_d;
            hits_q     <= hits_d;
            key_prev_q <= key_prev_d;
        end
    end

    assign start       = (state_q != IDLE);
    assign pause       = (state_q != PLAY);
    assign reset_level = (state_q == SERVE);
    assign game_over   = (state_q == GAME_OVER);
    assign win         = (state_q == WIN);
    assign score       = score_q;
    assign level       = level_q;
    assign life        = life_q;
    assign hits        = hits_q;

endmodule

// File: tb/tb_pinball_game_fsm.sv
// tb/tb_pinball_game_fsm.sv - self-checking bench for pinball_game_fsm
module tb_pinball_game_fsm;

    localparam int ST_IDLE = 0, ST_SERVE = 1, ST_PLAY = 2, ST_PAUSED = 3, ST_GO = 4, ST_WIN = 5;

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    // DUT A: default parameters
    logic a_ks = 0, a_kp = 0, a_cb = 0, a_co = 0;
    logic a_start, a_pause, a_rl, a_go, a_win;
    logic [7:0] a_score;
    logic [3:0] a_level;
    logic [2:0] a_life;
    logic [1:0] a_hits;

    // DUT B: narrow score, four levels
    logic b_ks = 0, b_kp = 0, b_cb = 0, b_co = 0;
    logic b_start, b_pause, b_rl, b_go, b_win;
    logic [3:0] b_score;
    logic [3:0] b_level;
    logic [2:0] b_life;
    logic [1:0] b_hits;

    pinball_game_fsm u_a (
        .clk(clk), .resetN(resetN),
        .key_start(a_ks), .key_pause(a_kp),
        .collision_bottom(a_cb), .collision_obstacle(a_co),
        .start(a_start), .pause(a_pause), .reset_level(a_rl),
        .game_over(a_go), .win(a_win),
        .score(a_score), .level(a_level), .life(a_life), .hits(a_hits)
    );

    pinball_game_fsm #(.SCORE_W(4), .MAX_LEVEL(4)) u_b (
        .clk(clk), .resetN(resetN),
        .key_start(b_ks), .key_pause(b_kp),
        .collision_bottom(b_cb), .collision_obstacle(b_co),
        .start(b_start), .pause(b_pause), .reset_level(b_rl),
        .game_over(b_go), .win(b_win),
        .score(b_score), .level(b_level), .life(b_life), .hits(b_hits)
    );

    typedef struct {
        string       tag;
        bit          sel;
        logic [21:0] val;
    } exp_t;

    exp_t sb[$];
    int n_pass = 0;
    int n_total = 0;

    // {start, pause, reset_level, game_over, win} for each state
    function automatic logic [4:0] dec(input int st);
        case (st)
            ST_IDLE:   return 5'b01000;
            ST_SERVE:  return 5'b11100;
            ST_PLAY:   return 5'b10000;
            ST_PAUSED: return 5'b11000;
            ST_GO:     return 5'b11010;
            default:   return 5'b11001;
        endcase
    endfunction

    function automatic logic [21:0] snap(input bit sel);
        if (sel)
            return {b_start, b_pause, b_rl, b_go, b_win, 4'b0000, b_score, b_level, b_life, b_hits};
        return {a_start, a_pause, a_rl, a_go, a_win, a_score, a_level, a_life, a_hits};
    endfunction

    task automatic push(input string tag, input bit sel, input int st, input int sc,
                        input int lv, input int lf, input int ht);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = {dec(st), 8'(sc), 4'(lv), 3'(lf), 2'(ht)};
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        logic [21:0] obs;
        n_total++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty observed=%0d expected=1", sb.size());
        end else begin
            e = sb.pop_front();
            obs = snap(e.sel);
            assert (obs === e.val) n_pass++;
            else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
        end
    endtask

    // Drive the given inputs high for one cycle; state updates on the posedge in between
    task automatic pulse(input bit sel, input logic s, input logic p, input logic b, input logic o);
        @(negedge clk);
        if (sel) begin b_ks = s; b_kp = p; b_cb = b; b_co = o; end
        else     begin a_ks = s; a_kp = p; a_cb = b; a_co = o; end
        @(negedge clk);
        a_ks = 0; a_kp = 0; a_cb = 0; a_co = 0;
        b_ks = 0; b_kp = 0; b_cb = 0; b_co = 0;
    endtask

    task automatic hold_a(input logic s, input logic p, input logic b, input logic o, input int n);
        @(negedge clk);
        a_ks = s; a_kp = p; a_cb = b; a_co = o;
        repeat (n) @(negedge clk);
        a_ks = 0; a_kp = 0; a_cb = 0; a_co = 0;
    endtask

    task automatic step(input bit sel, input logic s, input logic p, input logic b, input logic o,
                        input string tag, input int st, input int sc, input int lv,
                        input int lf, input int ht);
        push(tag, sel, st, sc, lv, lf, ht);
        pulse(sel, s, p, b, o);
        check_pop();
    endtask

    int life_e;
    int score_e;

    initial begin
        resetN = 1'b0;
        repeat (3) @(negedge clk);
        push("reset_a", 0, ST_IDLE, 0, 0, 3, 0); check_pop();
        push("reset_b", 1, ST_IDLE, 0, 0, 3, 0); check_pop();
        resetN = 1'b1;
        @(negedge clk);
        push("idle_after_release", 0, ST_IDLE, 0, 0, 3, 0); check_pop();

        // New game, two hits clear level 0
        step(0, 1, 0, 0, 0, "serve",      ST_SERVE, 0, 0, 3, 0);
        step(0, 1, 0, 0, 0, "play",       ST_PLAY,  0, 0, 3, 0);
        step(0, 0, 0, 0, 1, "hit1",       ST_PLAY,  5, 0, 3, 1);
`ifdef PINBALL_BONUS_LIFE_EN
        life_e = 4;
`else
        life_e = 3;
`endif
        step(0, 0, 0, 0, 1, "hit2_level", ST_SERVE, 10, 1, life_e, 0);
        step(0, 1, 0, 0, 0, "play_l1",    ST_PLAY,  10, 1, life_e, 0);

        // Lose every ball
        while (life_e > 1) begin
            life_e--;
            step(0, 0, 0, 1, 0, "bottom",    ST_SERVE, 10, 1, life_e, 0);
            step(0, 1, 0, 0, 0, "reserve",   ST_PLAY,  10, 1, life_e, 0);
        end
        step(0, 0, 0, 1, 0, "last_ball",  ST_GO,   10, 1, 0, 0);
        step(0, 0, 0, 0, 1, "go_ignore",  ST_GO,   10, 1, 0, 0);
        step(0, 1, 0, 0, 0, "go_idle",    ST_IDLE, 10, 1, 0, 0);
        step(0, 1, 0, 0, 0, "new_game",   ST_SERVE, 0, 0, 3, 0);
        step(0, 1, 0, 0, 0, "play2",      ST_PLAY,  0, 0, 3, 0);

        // Bottom and obstacle together: bottom wins, no score
        step(0, 0, 0, 1, 1, "both_coll",  ST_SERVE, 0, 0, 2, 0);
        step(0, 1, 0, 0, 0, "play3",      ST_PLAY,  0, 0, 2, 0);

        // Pause and collisions while paused
        step(0, 0, 1, 0, 0, "pause_on",   ST_PAUSED, 0, 0, 2, 0);
        step(0, 0, 0, 0, 1, "paused_obs", ST_PAUSED, 0, 0, 2, 0);
        step(0, 0, 0, 1, 0, "paused_bot", ST_PAUSED, 0, 0, 2, 0);
        step(0, 0, 1, 0, 0, "pause_off",  ST_PLAY,   0, 0, 2, 0);
        step(0, 0, 1, 0, 1, "obs_vs_pause", ST_PLAY, 5, 0, 2, 1);

        // Inputs held high count once
        step(0, 0, 1, 0, 0, "pause_on2",  ST_PAUSED, 5, 0, 2, 1);
        step(0, 0, 1, 0, 0, "pause_off2", ST_PLAY,   5, 0, 2, 1);
        push("hold_bottom", 0, ST_SERVE, 5, 0, 1, 1);
        hold_a(0, 0, 1, 0, 10);
        check_pop();
        push("hold_start", 0, ST_PLAY, 5, 0, 1, 1);
        hold_a(1, 0, 0, 0, 10);
        check_pop();

        // DUT B: score saturation and win
        step(1, 1, 0, 0, 0, "b_serve", ST_SERVE, 0, 0, 3, 0);
        step(1, 1, 0, 0, 0, "b_play",  ST_PLAY,  0, 0, 3, 0);
        life_e  = 3;
        score_e = 0;
        for (int lv = 0; lv < 4; lv++) begin
            score_e = (score_e + 5 > 15) ? 15 : score_e + 5;
            step(1, 0, 0, 0, 1, "b_hit_a", ST_PLAY, score_e, lv, life_e, 1);
            score_e = (score_e + 5 > 15) ? 15 : score_e + 5;
            if (lv == 3) begin
                step(1, 0, 0, 0, 1, "b_win", ST_WIN, score_e, 3, life_e, 0);
            end else begin
`ifdef PINBALL_BONUS_LIFE_EN
                if (life_e < 5) life_e++;
`endif
                step(1, 0, 0, 0, 1, "b_level_up", ST_SERVE, score_e, lv + 1, life_e, 0);
                step(1, 1, 0, 0, 0, "b_reserve",  ST_PLAY,  score_e, lv + 1, life_e, 0);
            end
        end
        step(1, 1, 0, 0, 0, "b_win_idle", ST_IDLE, 15, 3, life_e, 0);

        // Asynchronous reset in the middle of PLAY
        @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        push("async_reset_a", 0, ST_IDLE, 0, 0, 3, 0); check_pop();
        push("async_reset_b", 1, ST_IDLE, 0, 0, 3, 0); check_pop();
        resetN = 1'b1;
        repeat (2) @(negedge clk);
        push("post_reset_quiet", 0, ST_IDLE, 0, 0, 3, 0); check_pop();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
